// File: rtl/data_ram_ctrl_pkg.sv
// Shared types and helpers for the RV32 data memory controller.
package data_ram_ctrl_pkg;

   // Access size encoding as presented on the load/store path
   typedef enum logic [1:0] {
      SZ_B = 2'b00,
      SZ_H = 2'b01,
      SZ_W = 2'b10,
      SZ_X = 2'b11
   } size_e;

   // Controller state: zero sweep in progress, or serving requests
   typedef enum logic {
      CLEAR = 1'b0,
      IDLE  = 1'b1
   } state_e;

   // Byte lanes touched by an access of the given size at the given byte offset
   function automatic logic [3:0] lane_mask(input size_e size, input logic [1:0] addr_lo);
      logic [3:0] mask;
      mask = 4'b0000;
      case (size)
         SZ_B:    mask = 4'b0001 << addr_lo;
         SZ_H:    mask = addr_lo[1] ? 4'b1100 : 4'b0011;
         SZ_W:    mask = 4'b1111;
         default: mask = 4'b0000;
      endcase
      return mask;
   endfunction

endpackage

// File: rtl/data_ram_ctrl_if.sv
// Request/response bus between the load/store unit and the data memory.
interface data_ram_ctrl_if #(
   parameter int ADDR_W = 32
);
   import data_ram_ctrl_pkg::*;

   logic              req_i;
   logic              we_i;
   logic [ADDR_W-1:0] addr_i;
   size_e             size_i;
   logic              unsigned_i;
   logic [31:0]       wdata_i;
   logic              ready_o;
   logic              rvalid_o;
   logic [31:0]       rdata_o;
   logic              err_o;

   modport master (
      output req_i, we_i, addr_i, size_i, unsigned_i, wdata_i,
      input  ready_o, rvalid_o, rdata_o, err_o
   );

   modport slave (
      input  req_i, we_i, addr_i, size_i, unsigned_i, wdata_i,
      output ready_o, rvalid_o, rdata_o, err_o
   );

endinterface

// File: rtl/data_ram_ctrl_align.sv
// Byte-lane steering: replicates store data across lanes with a write mask,
// and extracts/extends the addressed byte or halfword of a loaded word.
module data_ram_ctrl_align
   import data_ram_ctrl_pkg::*;
(
   input  size_e       size,
   input  logic [1:0]  addr_lo,
   input  logic        is_unsigned,
   input  logic [31:0] store_data,
   input  logic [31:0] read_word,
   output logic [3:0]  lane_en,
   output logic [31:0] lane_data,
   output logic [31:0] load_data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Store side: replicate data so the lane mask alone selects destination bytes
   always_comb begin
      lane_en   = lane_mask(size, addr_lo);
      lane_data = store_data;
      case (size)
         SZ_B:    lane_data = {4{store_data[7:0]}};
         SZ_H:    lane_data = {2{store_data[15:0]}};
         default: lane_data = store_data;
      endcase
   end

   // Load side: pick the addressed lane(s) and sign- or zero-extend to 32 bits
   always_comb begin
      byte_sel  = read_word[{addr_lo, 3'b000} +: 8];
      half_sel  = addr_lo[1] ? read_word[31:16] : read_word[15:0];
      load_data = '0;
      case (size)
         SZ_B:    load_data = is_unsigned ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
         SZ_H:    load_data = is_unsigned ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
         SZ_W:    load_data = read_word;
         default: load_data = '0;
      endcase
   end

endmodule

// File: rtl/data_ram_ctrl.sv
// RV32IM data memory: word array with byte-lane stores, sized loads, a
// one-cycle registered response, and a per-word zeroing sweep after reset
// or on request. Bad accesses are flagged and never touch the array.
module data_ram_ctrl
   import data_ram_ctrl_pkg::*;
#(
   parameter int DEPTH  = 512,
   parameter int ADDR_W = 32
) (
   input  logic            clk,
   input  logic            reset_ni,
   input  logic            clear_i,
   output logic            busy_o,
   data_ram_ctrl_if.slave  bus
);

   localparam int               IDX_W    = $clog2(DEPTH);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

   state_e             state;
   logic [IDX_W-1:0]   sweep_idx;
   logic [31:0]        mem [DEPTH];

   logic               accept;
   logic               access_err;
   logic               store_en;
   logic [IDX_W-1:0]   word_idx;
   logic [31:0]        read_word;
   logic [3:0]         lane_en;
   logic [31:0]        lane_data;
   logic [31:0]        load_data;

   logic               rvalid_q;
   logic               err_q;
   logic [31:0]        rdata_q;

   assign bus.ready_o  = (state == IDLE) && !clear_i;
   assign busy_o       = (state == CLEAR);
   assign bus.rvalid_o = rvalid_q;
   assign bus.err_o    = err_q;
   assign bus.rdata_o  = rdata_q;

   assign accept    = bus.req_i && bus.ready_o;
   assign word_idx  = bus.addr_i[IDX_W+1:2];
   assign store_en  = accept && bus.we_i && !access_err;
   assign read_word = mem[word_idx];

   // Classify the presented access: illegal size, misalignment, or beyond the array
   always_comb begin
      access_err = 1'b0;
      case (bus.size_i)
         SZ_H:    access_err = bus.addr_i[0];
         SZ_W:    access_err = |bus.addr_i[1:0];
         SZ_X:    access_err = 1'b1;
         default: access_err = 1'b0;
      endcase
      if ((bus.addr_i >> (IDX_W + 2)) != '0) begin
         access_err = 1'b1;
      end
   end

   data_ram_ctrl_align u_align (
      .size        (bus.size_i),
      .addr_lo     (bus.addr_i[1:0]),
      .is_unsigned (bus.unsigned_i),
      .store_data  (bus.wdata_i),
      .read_word   (read_word),
      .lane_en     (lane_en),
      .lane_data   (lane_data),
      .load_data   (load_data)
   );

   // Array write port: zero one word per cycle while sweeping, else masked store
   always_ff @(posedge clk) begin
      if (state == CLEAR) begin
         mem[sweep_idx] <= '0;
      end else if (store_en) begin
         for (int lane = 0; lane < 4; lane++) begin
            if (lane_en[lane]) begin
               mem[word_idx][8*lane +: 8] <= lane_data[8*lane +: 8];
            end
         end
      end
   end

   // Sweep/serve state machine with the registered response beat
   always_ff @(posedge clk or negedge reset_ni) begin
      if (!reset_ni) begin
         state     <= CLEAR;
         sweep_idx <= '0;
         rvalid_q  <= 1'b0;
         err_q     <= 1'b0;
         rdata_q   <= '0;
      end else begin
         case (state)
            CLEAR: begin
               rvalid_q <= 1'b0;
               err_q    <= 1'b0;
               rdata_q  <= '0;
               if (sweep_idx == LAST_IDX) begin
                  state     <= IDLE;
                  sweep_idx <= '0;
               end else begin
                  sweep_idx <= sweep_idx + IDX_W'(1);
               end
            end
            IDLE: begin
               if (clear_i) begin
                  state     <= CLEAR;
                  sweep_idx <= '0;
                  rvalid_q  <= 1'b0;
                  err_q     <= 1'b0;
                  rdata_q   <= '0;
               end else begin
                  rvalid_q <= accept;
                  err_q    <= accept && access_err;
                  rdata_q  <= (accept && !bus.we_i && !access_err) ? load_data : '0;
               end
            end
            default: begin
               state     <= CLEAR;
               sweep_idx <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_data_ram_ctrl.sv
// Self-checking bench for data_ram_ctrl: directed vector table, random
// accesses against a byte-addressed reference memory, and sweep/reset sequences.
module tb_data_ram_ctrl;
   import data_ram_ctrl_pkg::*;

   localparam int DEPTH = 512;
   localparam int BYTES = DEPTH * 4;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] wdata;
      logic        exp_err;
      logic [31:0] exp_rdata;
      string       name;
   } vec_t;

   logic clk      = 1'b0;
   logic reset_ni = 1'b0;
   logic clear_i  = 1'b0;
   logic busy_o;

   int total = 0;
   int bad   = 0;

   logic [7:0] model_mem [BYTES];
   vec_t       vecs [$];

   data_ram_ctrl_if #(.ADDR_W(32)) bus ();

   data_ram_ctrl #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
      .clk      (clk),
      .reset_ni (reset_ni),
      .clear_i  (clear_i),
      .busy_o   (busy_o),
      .bus      (bus.slave)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Safety net so the run always ends
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
      end
   endtask

   // Reference: byte-addressed memory, little-endian, plain arithmetic
   function automatic void modelAccess(input logic we, input logic [31:0] addr, input logic [1:0] size,
                                       input logic uns, input logic [31:0] wdata,
                                       output logic err, output logic [31:0] rdata);
      int n;
      n     = 1 << size;
      err   = (size == 2'b11) || (size == 2'b01 && addr[0]) ||
              (size == 2'b10 && addr[1:0] != 2'b00) || (addr >= 32'(BYTES));
      rdata = 32'h0;
      if (!err) begin
         if (we) begin
            for (int i = 0; i < n; i++) model_mem[addr + 32'(i)] = wdata[8*i +: 8];
         end else begin
            for (int i = 0; i < n; i++) rdata[8*i +: 8] = model_mem[addr + 32'(i)];
            if (!uns && n < 4 && rdata[8*n-1]) begin
               for (int i = n; i < 4; i++) rdata[8*i +: 8] = 8'hFF;
            end
         end
      end
   endfunction

   function automatic void modelClear();
      for (int i = 0; i < BYTES; i++) model_mem[i] = 8'h00;
   endfunction

   // One access: drive at negedge, it is accepted at the next posedge, sample just after
   task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [1:0] size,
                                input logic uns, input logic [31:0] wdata,
                                output logic got_rvalid, output logic got_err, output logic [31:0] got_rdata);
      @(negedge clk);
      bus.req_i      = 1'b1;
      bus.we_i       = we;
      bus.addr_i     = addr;
      bus.size_i     = size_e'(size);
      bus.unsigned_i = uns;
      bus.wdata_i    = wdata;
      #1;
      checkOutput("ready_before_accept", bus.ready_o, 1);
      @(posedge clk);
      #1;
      got_rvalid = bus.rvalid_o;
      got_err    = bus.err_o;
      got_rdata  = bus.rdata_o;
   endtask

   task automatic goIdle();
      @(negedge clk);
      bus.req_i = 1'b0;
      bus.we_i  = 1'b0;
   endtask

   // Count cycles from a sweep start until ready rises, bounded
   task automatic waitReady(input string name);
      int   cycles = 0;
      logic saw    = 1'b0;
      checkOutput({name, "_busy_high"}, busy_o, 1);
      while (!bus.ready_o && cycles < 4000) begin
         @(posedge clk);
         #1;
         cycles++;
         if (bus.rvalid_o) saw = 1'b1;
      end
      checkOutput({name, "_cycles"}, cycles, DEPTH);
      checkOutput({name, "_no_response"}, saw, 0);
      checkOutput({name, "_busy_low"}, busy_o, 0);
   endtask

   // Compare one access against given expectations
   task automatic checkAccess(input string name, input logic we, input logic [31:0] addr, input logic [1:0] size,
                              input logic uns, input logic [31:0] wdata, input logic exp_err, input logic [31:0] exp_rdata);
      logic        r, e, m_err;
      logic [31:0] d, m_rdata;
      modelAccess(we, addr, size, uns, wdata, m_err, m_rdata);
      applyStimulus(we, addr, size, uns, wdata, r, e, d);
      checkOutput({name, "_rvalid"}, r, 1);
      checkOutput({name, "_err"}, e, exp_err);
      checkOutput({name, "_rdata"}, d, exp_rdata);
   endtask

   // Main sequence
   initial begin
      logic        r, e, m_err, we, uns;
      logic [31:0] d, m_rdata, addr, wdata;
      logic [1:0]  size;

      bus.req_i      = 1'b0;
      bus.we_i       = 1'b0;
      bus.addr_i     = 32'h10;
      bus.size_i     = SZ_W;
      bus.unsigned_i = 1'b0;
      bus.wdata_i    = 32'h0;
      modelClear();

      #2;
      checkOutput("reset_ready", bus.ready_o, 0);
      checkOutput("reset_rvalid", bus.rvalid_o, 0);
      checkOutput("reset_rdata", bus.rdata_o, 0);
      checkOutput("reset_err", bus.err_o, 0);
      checkOutput("reset_busy", busy_o, 1);

      bus.req_i = 1'b1;
      @(negedge clk);
      reset_ni = 1'b1;
      waitReady("init_sweep");
      goIdle();

      vecs.push_back('{1'b1, 32'h010, 2'b10, 1'b0, 32'hDEADBEEF, 1'b0, 32'h00000000, "sw_10"});
      vecs.push_back('{1'b0, 32'h010, 2'b10, 1'b0, 32'h0,        1'b0, 32'hDEADBEEF, "lw_10"});
      vecs.push_back('{1'b1, 32'h011, 2'b00, 1'b0, 32'h00000080, 1'b0, 32'h00000000, "sb_11"});
      vecs.push_back('{1'b0, 32'h011, 2'b00, 1'b0, 32'h0,        1'b0, 32'hFFFFFF80, "lb_11"});
      vecs.push_back('{1'b0, 32'h011, 2'b00, 1'b1, 32'h0,        1'b0, 32'h00000080, "lbu_11"});
      vecs.push_back('{1'b0, 32'h010, 2'b10, 1'b0, 32'h0,        1'b0, 32'hDEAD80EF, "lw_10_b"});
      vecs.push_back('{1'b1, 32'h013, 2'b01, 1'b0, 32'h00001234, 1'b1, 32'h00000000, "sh_13_mis"});
      vecs.push_back('{1'b0, 32'h010, 2'b10, 1'b0, 32'h0,        1'b0, 32'hDEAD80EF, "lw_10_c"});
      vecs.push_back('{1'b0, 32'h800, 2'b10, 1'b0, 32'h0,        1'b1, 32'h00000000, "lw_800_oor"});
      vecs.push_back('{1'b0, 32'h010, 2'b11, 1'b0, 32'h0,        1'b1, 32'h00000000, "size_x"});
      vecs.push_back('{1'b1, 32'h012, 2'b01, 1'b0, 32'h0000ABCD, 1'b0, 32'h00000000, "sh_12"});
      vecs.push_back('{1'b0, 32'h012, 2'b01, 1'b0, 32'h0,        1'b0, 32'hFFFFABCD, "lh_12"});
      vecs.push_back('{1'b0, 32'h012, 2'b01, 1'b1, 32'h0,        1'b0, 32'h0000ABCD, "lhu_12"});
      vecs.push_back('{1'b0, 32'h010, 2'b10, 1'b0, 32'h0,        1'b0, 32'hABCD80EF, "lw_10_d"});
      vecs.push_back('{1'b1, 32'h7FC, 2'b10, 1'b0, 32'h12345678, 1'b0, 32'h00000000, "sw_last"});
      vecs.push_back('{1'b0, 32'h7FF, 2'b00, 1'b0, 32'h0,        1'b0, 32'h00000012, "lb_7ff"});
      vecs.push_back('{1'b0, 32'h7FE, 2'b10, 1'b0, 32'h0,        1'b1, 32'h00000000, "lw_7fe_mis"});
      vecs.push_back('{1'b1, 32'h800, 2'b00, 1'b0, 32'h000000FF, 1'b1, 32'h00000000, "sb_800_oor"});
      vecs.push_back('{1'b0, 32'h000, 2'b10, 1'b0, 32'h0,        1'b0, 32'h00000000, "lw_0"});
      vecs.push_back('{1'b1, 32'h004, 2'b01, 1'b0, 32'hFFFF8001, 1'b0, 32'h00000000, "sh_4"});
      vecs.push_back('{1'b0, 32'h004, 2'b01, 1'b0, 32'h0,        1'b0, 32'hFFFF8001, "lh_4"});
      vecs.push_back('{1'b0, 32'h004, 2'b10, 1'b0, 32'h0,        1'b0, 32'h00008001, "lw_4"});

      foreach (vecs[i]) begin
         checkAccess(vecs[i].name, vecs[i].we, vecs[i].addr, vecs[i].size, vecs[i].uns,
                     vecs[i].wdata, vecs[i].exp_err, vecs[i].exp_rdata);
      end
      goIdle();
      @(posedge clk);
      #1;
      checkOutput("rvalid_idle", bus.rvalid_o, 0);

      for (int n = 0; n < 300; n++) begin
         we    = 1'($urandom_range(0, 1));
         uns   = 1'($urandom_range(0, 1));
         size  = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
         addr  = ($urandom_range(0, 19) == 0) ? $urandom : 32'($urandom_range(0, BYTES - 1));
         if (size != 2'b11 && $urandom_range(0, 3) != 0) addr = addr & ~((32'd1 << size) - 32'd1);
         wdata = $urandom;
         modelAccess(we, addr, size, uns, wdata, m_err, m_rdata);
         applyStimulus(we, addr, size, uns, wdata, r, e, d);
         checkOutput("rand_rvalid", r, 1);
         checkOutput("rand_err", e, m_err);
         checkOutput("rand_rdata", d, m_rdata);
      end
      goIdle();

      checkAccess("pre_clear_sw", 1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0);
      @(negedge clk);
      clear_i        = 1'b1;
      bus.req_i      = 1'b1;
      bus.we_i       = 1'b0;
      bus.addr_i     = 32'h10;
      bus.size_i     = SZ_W;
      #1;
      checkOutput("clear_blocks_ready", bus.ready_o, 0);
      @(posedge clk);
      #1;
      checkOutput("clear_no_accept", bus.rvalid_o, 0);
      @(negedge clk);
      clear_i   = 1'b0;
      bus.req_i = 1'b0;
      waitReady("clear_sweep");
      modelClear();
      checkAccess("post_clear_lw", 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 1'b0, 32'h0);
      checkAccess("post_clear_sw", 1'b1, 32'h20, 2'b10, 1'b0, 32'hCAFEF00D, 1'b0, 32'h0);
      goIdle();

      @(negedge clk);
      clear_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      clear_i = 1'b0;
      repeat (100) @(posedge clk);
      #2;
      reset_ni = 1'b0;
      #1;
      checkOutput("midsweep_reset_busy", busy_o, 1);
      checkOutput("midsweep_reset_ready", bus.ready_o, 0);
      checkOutput("midsweep_reset_rvalid", bus.rvalid_o, 0);
      @(negedge clk);
      reset_ni = 1'b1;
      waitReady("resweep");
      modelClear();
      checkAccess("resweep_lw", 1'b0, 32'h20, 2'b10, 1'b0, 32'h0, 1'b0, 32'h0);

      #1;
      reset_ni  = 1'b0;
      bus.req_i = 1'b0;
      #1;
      checkOutput("resp_reset_rvalid", bus.rvalid_o, 0);
      checkOutput("resp_reset_busy", busy_o, 1);
      @(negedge clk);
      reset_ni = 1'b1;
      waitReady("resp_reset_sweep");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
